// File: rtl/itof_sched_pkg.sv
// Shared helpers for the int-to-float issue scheduler.
// Width helpers and the deterministic idle operand.
package itof_sched_pkg;

    localparam logic [31:0] IDLE_X = 32'h0;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int entw(input int tagw, input int nreq);
        return 32 + tagw + idw(nreq);
    endfunction

endpackage

// File: rtl/itof_sched_fifo.sv
// First-word-fall-through result buffer for itof_sched.
// Head is zero while empty so res_* stay clean after reset.
module itof_sched_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wr <= wr + AW'(1);
            end
            if (do_pop) begin
                rd <= rd + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/itof_sched.sv
// Round-robin scheduler sharing one int-to-float converter among NREQ ports.
// Optional counters: define ITOF_SCHED_STATS_EN for stat_issue/stat_stall.
module itof_sched
    import itof_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LAT   = 1,
    parameter int TAGW  = 5,
    parameter int DEPTH = 4,
    localparam int IDW  = idw(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_data,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          cvt_x,
    input  logic [31:0]          cvt_y,
    output logic                 res_valid,
    output logic [31:0]          res_data,
    output logic [TAGW-1:0]      res_tag,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_ready
`ifdef ITOF_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issue,
    output logic [31:0]          stat_stall
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]     data;
        logic [TAGW-1:0] tag;
        logic [IDW-1:0]  id;
    } ent_t;

    logic [IDW-1:0]  rr;
    logic [IDW-1:0]  grant;
    logic            found;
    logic [CW-1:0]   cnt;
    logic            credit;
    logic            issue;
    logic            pop;
    logic            push;
    logic            ffull;
    logic            fempty;
    logic [LAT-1:0]  pv;
    logic [TAGW-1:0] ptag [LAT];
    logic [IDW-1:0]  pid  [LAT];
    ent_t            fin;
    ent_t            fout;

    always_comb begin
        int idx;
        logic [NREQ-1:0] sh;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        sh    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sh = req_valid >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    // Full FIFO gating is redundant with the credit count but keeps push safe.
    assign credit = (cnt < CW'(DEPTH)) & ~ffull;

    always_comb begin
        req_ready = '0;
        if (found && credit && !rst) begin
            req_ready = NREQ'(1) << grant;
        end
    end

    assign issue = |(req_valid & req_ready);
    assign cvt_x = issue ? req_data[32*int'(grant) +: 32] : IDLE_X;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr  <= '0;
            cnt <= '0;
        end else begin
            if (issue) begin
                rr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
            end
            cnt <= cnt + CW'(issue) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++) begin
                ptag[i] <= '0;
                pid[i]  <= '0;
            end
        end else begin
            pv[0]   <= issue;
            ptag[0] <= issue ? req_tag[TAGW*int'(grant) +: TAGW] : '0;
            pid[0]  <= issue ? grant : '0;
            for (int i = 1; i < LAT; i++) begin
                pv[i]   <= pv[i-1];
                ptag[i] <= ptag[i-1];
                pid[i]  <= pid[i-1];
            end
        end
    end

    assign push = pv[LAT-1];
    assign fin  = '{data: cvt_y, tag: ptag[LAT-1], id: pid[LAT-1]};
    assign pop  = res_valid & res_ready;

    itof_sched_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fin),
        .pop   (pop),
        .dout  (fout),
        .full  (ffull),
        .empty (fempty)
    );

    assign res_valid = ~fempty;
    assign res_data  = fout.data;
    assign res_tag   = fout.tag;
    assign res_id    = fout.id;

`ifdef ITOF_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (issue) begin
                stat_issue <= stat_issue + 32'd1;
            end
            if (|req_valid && !issue) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_itof_sched.sv
// Self-checking bench for itof_sched with a queue-based reference model.
// The converter is modelled here as a 1-cycle register with RNE rounding.
module tb_itof_sched;

    localparam int NREQ  = 2;
    localparam int LAT   = 1;
    localparam int TAGW  = 5;
    localparam int DEPTH = 4;
    localparam int IDW   = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          cvt_x;
    logic [31:0]          cvt_y = 32'h0;
    logic                 res_valid;
    logic [31:0]          res_data;
    logic [TAGW-1:0]      res_tag;
    logic [IDW-1:0]       res_id;
    logic                 res_ready;
`ifdef ITOF_SCHED_STATS_EN
    logic [31:0]          stat_issue;
    logic [31:0]          stat_stall;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    itof_sched #(
        .NREQ  (NREQ),
        .LAT   (LAT),
        .TAGW  (TAGW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .cvt_x     (cvt_x),
        .cvt_y     (cvt_y),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_id    (res_id),
        .res_ready (res_ready)
`ifdef ITOF_SCHED_STATS_EN
        ,
        .stat_issue (stat_issue),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f32(input logic [31:0] x);
        logic        s;
        logic [31:0] m;
        logic [31:0] mant;
        logic [31:0] rem;
        logic [31:0] half;
        int          p;
        int          sh;
        int          e;
        if (x == 32'h0) return 32'h0;
        s = x[31];
        m = s ? (~x + 32'd1) : x;
        p = 31;
        while (!m[p]) p--;
        e = 127 + p;
        if (p <= 23) begin
            mant = m << (23 - p);
        end else begin
            sh   = p - 23;
            mant = m >> sh;
            rem  = m & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                e++;
            end
        end
        return {s, e[7:0], mant[22:0]};
    endfunction

    always @(posedge clk) cvt_y <= f32(cvt_x);

    typedef struct {
        logic [31:0]     d;
        logic [TAGW-1:0] t;
        logic [IDW-1:0]  id;
        int              vis;
    } exp_t;

    exp_t q[$];
    int   rr_m = 0;

    // Reference: credit = queued entries, result visible LAT+1 cycles after issue.
    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int              g;
        int              j;
        bit              ev;
        exp_t            e;
        cyc++;
        if (rst) begin
            q.delete();
            rr_m = 0;
            tests++;
            if (req_ready !== '0 || res_valid !== 1'b0 || res_data !== 32'h0 ||
                res_tag !== '0 || res_id !== '0) begin
                fails++;
                $display("FAIL mon_reset rdy=%b v=%b d=%h t=%h id=%h want all 0",
                         req_ready, res_valid, res_data, res_tag, res_id);
            end
        end else begin
            er = '0;
            g  = -1;
            if (q.size() < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (rr_m + k) % NREQ;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            tests++;
            if (req_ready !== er) begin
                fails++;
                $display("FAIL mon_grant cyc=%0d got=%b want=%b", cyc, req_ready, er);
            end
            ev = (q.size() > 0) && (q[0].vis <= cyc);
            tests++;
            if (res_valid !== ev) begin
                fails++;
                $display("FAIL mon_valid cyc=%0d got=%b want=%b", cyc, res_valid, ev);
            end
            if (ev) begin
                tests++;
                if (res_data !== q[0].d || res_tag !== q[0].t || res_id !== q[0].id) begin
                    fails++;
                    $display("FAIL mon_data cyc=%0d got=%h/%h/%h want=%h/%h/%h", cyc,
                             res_data, res_tag, res_id, q[0].d, q[0].t, q[0].id);
                end
                if (res_ready) void'(q.pop_front());
            end
            if (g >= 0) begin
                e.d   = f32(req_data[32*g +: 32]);
                e.t   = req_tag[TAGW*g +: TAGW];
                e.id  = g[IDW-1:0];
                e.vis = cyc + LAT + 1;
                q.push_back(e);
                rr_m = (g + 1) % NREQ;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_tag = '0;
        res_ready = 1'b1;
        tick();
        tick();
        tests++;
        if (res_valid !== 1'b0 || res_data !== 32'h0 || res_tag !== '0 || res_id !== '0) begin
            fails++;
            $display("FAIL reset_res v=%b d=%h t=%h id=%h want 0", res_valid, res_data, res_tag, res_id);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (req_ready !== '0) begin
            fails++;
            $display("FAIL reset_ready got=%b want=00", req_ready);
        end
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        req_data[31:0] = 32'd5;
        req_tag[TAGW-1:0] = 5'd3;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL single_grant got=%b want=01", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early got=%b want=0", res_valid);
        end
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'h40A00000 || res_tag !== 5'd3 || res_id !== 1'b0) begin
            fails++;
            $display("FAIL single_res got=%b/%h/%h/%h want=1/40a00000/03/0",
                     res_valid, res_data, res_tag, res_id);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        req_valid = 2'b10;
        req_data[63:32] = 32'hFFFFFFFF;
        req_tag[2*TAGW-1:TAGW] = 5'd7;
        tick();
        req_data[63:32] = 32'h0;
        req_tag[2*TAGW-1:TAGW] = 5'd9;
        tick();
        req_valid = '0;
        #1;
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'hBF800000 || res_tag !== 5'd7 || res_id !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first got=%b/%h/%h/%h want=1/bf800000/07/1",
                     res_valid, res_data, res_tag, res_id);
        end
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'h0 || res_tag !== 5'd9 || res_id !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second got=%b/%h/%h/%h want=1/00000000/09/1",
                     res_valid, res_data, res_tag, res_id);
        end
        tick();
        tick();
    endtask

    task automatic test_alternate();
        logic [NREQ-1:0] ep;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            req_data = {$urandom, $urandom};
            req_tag = NREQ*TAGW'($urandom);
            ep = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            tests++;
            if (req_ready !== ep) begin
                fails++;
                $display("FAIL alt_grant i=%0d got=%b want=%b", i, req_ready, ep);
            end
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
    endtask

    task automatic test_backpressure();
        int n;
        res_ready = 1'b0;
        req_valid = 2'b01;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            req_data[31:0] = $urandom;
            req_tag[TAGW-1:0] = TAGW'($urandom);
            #1;
            if (req_ready[0]) n++;
            tick();
        end
        tests++;
        if (n !== DEPTH) begin
            fails++;
            $display("FAIL bp_issues got=%0d want=%0d", n, DEPTH);
        end
        tests++;
        if (req_ready !== '0) begin
            fails++;
            $display("FAIL bp_stalled got=%b want=00", req_ready);
        end
        res_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== '0) begin
            fails++;
            $display("FAIL bp_popcycle got=%b want=00", req_ready);
        end
        tick();
        res_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            req_data[31:0] = $urandom;
            #1;
            if (req_ready[0]) n++;
            tick();
        end
        tests++;
        if (n !== 1) begin
            fails++;
            $display("FAIL bp_refill got=%0d want=1", n);
        end
    endtask

    task automatic test_full_pop_issue();
        res_ready = 1'b1;
        req_valid = 2'b01;
        for (int i = 0; i < 10; i++) begin
            req_data[31:0] = $urandom;
            req_tag[TAGW-1:0] = TAGW'($urandom);
            #1;
            tests++;
            if (res_valid !== 1'b1) begin
                fails++;
                $display("FAIL full_valid i=%0d got=%b want=1", i, res_valid);
            end
            if (i >= 1) begin
                tests++;
                if (req_ready !== 2'b01) begin
                    fails++;
                    $display("FAIL full_issue i=%0d got=%b want=01", i, req_ready);
                end
            end
            tick();
        end
        req_valid = '0;
        repeat (6) tick();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_drain got=%b want=0", res_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req_valid = NREQ'($urandom_range(0, 3));
            req_data = {$urandom, $urandom};
            req_tag = NREQ*TAGW'($urandom);
            res_ready = ($urandom % 4) != 0;
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (12) tick();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL rand_drain got=%b want=0", res_valid);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_data[31:0] = $urandom;
            tick();
        end
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got=%b want=0", res_valid);
        end
        tick();
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (res_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_after i=%0d got=%b want=0", i, res_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_backpressure();
        test_full_pop_issue();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
